// File: rtl/onehot_serial_encoder32.sv
// onehot_serial_encoder32: serialises a 32-bit one-hot/request vector into
// one 5-bit binary index per handshake, lowest index first by default.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   in_vec is valid
//   in_ready   block can accept a vector (registered)
//   in_vec     vector to encode, bit i set = index i pending
//   out_valid  out_index valid (registered)
//   out_ready  consumer accepts out_index
//   out_index  binary index of the bit currently presented
//   out_last   presented index is the final pending bit of the vector
//   pend_cnt   pending bits including the one presented, 0..32
//   done       one-cycle pulse: vector drained or zero vector consumed
//   abort      synchronous flush of the current vector
//
// Build option: define ENC32_MSB_FIRST_EN to emit indices highest-first.

module onehot_serial_encoder32 #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic [IDX_W:0]   pend_cnt,
    output logic             done,
    input  logic             abort
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pend;

    // Index of the next bit to present from a vector.
    function automatic logic [IDX_W-1:0] pick(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
`ifdef ENC32_MSB_FIRST_EN
        // Ascending scan: the last hit wins, i.e. the highest set bit.
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) r = IDX_W'(i);
        end
`else
        // Descending scan: the last hit wins, i.e. the lowest set bit.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
`endif
        return r;
    endfunction

    // Six-bit population count so a full vector reads 32 without wrap.
    function automatic logic [IDX_W:0] popcnt(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{IDX_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic             acc;
    logic             hs;
    logic [WIDTH-1:0] one;
    logic [WIDTH-1:0] nxt_pend;
    logic [IDX_W-1:0] in_idx;
    logic [IDX_W:0]   in_cnt;
    logic [IDX_W-1:0] nxt_idx;
    logic [IDX_W:0]   nxt_cnt;

    always_comb begin
        acc      = in_valid && in_ready;
        hs       = out_valid && out_ready;
        one      = {{(WIDTH-1){1'b0}}, 1'b1};
        // Pending set once the presented bit is consumed.
        nxt_pend = pend & ~(one << out_index);
        in_idx   = pick(in_vec);
        in_cnt   = popcnt(in_vec);
        nxt_idx  = pick(nxt_pend);
        nxt_cnt  = pend_cnt - {{IDX_W{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
            pend_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Flush wins over any handshake in the same cycle.
                state     <= IDLE;
                pend      <= '0;
                in_ready  <= 1'b1;
                out_valid <= 1'b0;
                out_index <= '0;
                out_last  <= 1'b0;
                pend_cnt  <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (acc) begin
                            if (|in_vec) begin
                                state     <= EMIT;
                                pend      <= in_vec;
                                in_ready  <= 1'b0;
                                out_valid <= 1'b1;
                                out_index <= in_idx;
                                pend_cnt  <= in_cnt;
                                out_last  <= (in_cnt == 6'd1);
                            end else begin
                                // Zero vector: nothing to emit.
                                done <= 1'b1;
                            end
                        end
                    end
                    EMIT: begin
                        if (hs) begin
                            if (out_last) begin
                                state     <= IDLE;
                                pend      <= '0;
                                in_ready  <= 1'b1;
                                out_valid <= 1'b0;
                                out_index <= '0;
                                out_last  <= 1'b0;
                                pend_cnt  <= '0;
                                done      <= 1'b1;
                            end else begin
                                pend      <= nxt_pend;
                                out_index <= nxt_idx;
                                pend_cnt  <= nxt_cnt;
                                out_last  <= (nxt_cnt == 6'd1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_onehot_serial_encoder32.sv
// tb_onehot_serial_encoder32: directed self-checking bench for
// onehot_serial_encoder32 (both emission orders).

module tb_onehot_serial_encoder32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic        out_last;
    logic [5:0]  pend_cnt;
    logic        done;
    logic        abort;

    int total = 0;
    int bad   = 0;

    onehot_serial_encoder32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .pend_cnt  (pend_cnt),
        .done      (done),
        .abort     (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

`ifdef ENC32_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    initial begin
        logic [4:0] e3 [3];
        if (MSB) begin
            e3[0] = 5'd31; e3[1] = 5'd4; e3[2] = 5'd0;
        end else begin
            e3[0] = 5'd0; e3[1] = 5'd4; e3[2] = 5'd31;
        end

        rst_n = 1'b0; in_valid = 1'b0; in_vec = '0;
        out_ready = 1'b0; abort = 1'b0;

        // Reset then idle
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_index", 32'(out_index), 0);
        chk("rst_pend_cnt", 32'(pend_cnt), 0);
        chk("rst_done", 32'(done), 0);

        // One-hot input
        out_ready = 1'b1; in_valid = 1'b1; in_vec = 32'h0000_0400;
        tick();
        in_valid = 1'b0; in_vec = '0;
        chk("oh_valid", 32'(out_valid), 1);
        chk("oh_index", 32'(out_index), 10);
        chk("oh_last", 32'(out_last), 1);
        chk("oh_cnt", 32'(pend_cnt), 1);
        chk("oh_in_ready", 32'(in_ready), 0);
        chk("oh_no_done", 32'(done), 0);
        tick();
        chk("oh_done", 32'(done), 1);
        chk("oh_in_ready2", 32'(in_ready), 1);
        chk("oh_valid2", 32'(out_valid), 0);
        tick();
        chk("oh_done_pulse", 32'(done), 0);

        // Multi-bit with backpressure; later in_vec changes are ignored
        out_ready = 1'b0; in_valid = 1'b1; in_vec = 32'h8000_0011;
        tick();
        in_valid = 1'b0; in_vec = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_index", 32'(out_index), 32'(e3[0]));
            chk("bp_hold_cnt", 32'(pend_cnt), 3);
            chk("bp_hold_last", 32'(out_last), 0);
            tick();
        end
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            chk("mb_valid", 32'(out_valid), 1);
            chk("mb_index", 32'(out_index), 32'(e3[b]));
            chk("mb_cnt", 32'(pend_cnt), 32'(3 - b));
            chk("mb_last", 32'(out_last), (b == 2) ? 1 : 0);
            tick();
        end
        chk("mb_done", 32'(done), 1);
        chk("mb_valid_end", 32'(out_valid), 0);
        tick();

        // All ones
        in_valid = 1'b1; in_vec = 32'hFFFF_FFFF;
        tick();
        in_valid = 1'b0; in_vec = '0;
        for (int b = 0; b < 32; b++) begin
            chk("all_valid", 32'(out_valid), 1);
            chk("all_index", 32'(out_index), MSB ? 32'(31 - b) : 32'(b));
            chk("all_cnt", 32'(pend_cnt), 32'(32 - b));
            chk("all_last", 32'(out_last), (b == 31) ? 1 : 0);
            chk("all_no_done", 32'(done), 0);
            tick();
        end
        chk("all_done", 32'(done), 1);
        chk("all_valid_end", 32'(out_valid), 0);
        chk("all_in_ready", 32'(in_ready), 1);
        tick();
        chk("all_done_pulse", 32'(done), 0);

        // Zero vector
        in_valid = 1'b1; in_vec = '0;
        tick();
        in_valid = 1'b0;
        chk("zero_valid", 32'(out_valid), 0);
        chk("zero_done", 32'(done), 1);
        chk("zero_in_ready", 32'(in_ready), 1);
        tick();
        chk("zero_done_pulse", 32'(done), 0);
        chk("zero_valid2", 32'(out_valid), 0);

        // Abort on second beat
        in_valid = 1'b1; in_vec = 32'h0000_00F0;
        tick();
        in_valid = 1'b0;
        chk("ab_idx0", 32'(out_index), MSB ? 7 : 4);
        tick();
        chk("ab_idx1", 32'(out_index), MSB ? 6 : 5);
        chk("ab_cnt1", 32'(pend_cnt), 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_valid", 32'(out_valid), 0);
        chk("ab_in_ready", 32'(in_ready), 1);
        chk("ab_done", 32'(done), 0);
        chk("ab_cnt", 32'(pend_cnt), 0);
        tick();
        chk("ab_done2", 32'(done), 0);
        chk("ab_valid2", 32'(out_valid), 0);

        // Same with mid-vector reset
        in_valid = 1'b1; in_vec = 32'h0000_00F0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rs_idx1", 32'(out_index), MSB ? 6 : 5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rs_valid", 32'(out_valid), 0);
        chk("rs_in_ready", 32'(in_ready), 1);
        chk("rs_done", 32'(done), 0);
        chk("rs_cnt", 32'(pend_cnt), 0);
        tick();
        chk("rs_done2", 32'(done), 0);

        // Abort beats a simultaneous acceptance
        in_valid = 1'b1; in_vec = 32'h0000_0001; abort = 1'b1;
        tick();
        in_valid = 1'b0; abort = 1'b0;
        chk("abacc_valid", 32'(out_valid), 0);
        chk("abacc_in_ready", 32'(in_ready), 1);
        chk("abacc_done", 32'(done), 0);
        tick();
        chk("abacc_valid2", 32'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
